pulse_period_meter: RTL and testbench



---
 rtl/pulse_period_meter.sv | 120 ++++++++++++
 tb/tb_pulse_period_meter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures the number of enabled clock cycles between consecutive input pulses
// and presents each result through a valid/ack register with saturation and overrun flags.
module pulse_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             clear,
  input  logic             enable,
  input  logic             pulse,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ack,
  output logic             saturated,
  output logic             overrun,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

  // Handshake: period/saturated are meaningful while period_valid=1; the
  // consumer retires a result by holding period_ack=1 for one clock edge.
  // A capture on the same edge as an ack reloads the register without overrun.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             sat_q, sat_d;
  logic             overrun_q, overrun_d;

  logic             capture;
  logic [WIDTH-1:0] cap_val;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    valid_d   = valid_q;
    sat_d     = sat_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    cap_val   = '0;

    if (enable) begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          if (pulse) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (pulse) begin
            capture = 1'b1;
            cap_val = (count_q == MAX_COUNT) ? MAX_COUNT : count_q + 1'b1;
            count_d = '0;
          end else if (count_q != MAX_COUNT) begin
            count_d = count_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    if (capture) begin
      period_d = cap_val;
      sat_d    = (cap_val == MAX_COUNT);
      valid_d  = 1'b1;
      if (valid_q && !period_ack) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && period_ack) begin
      valid_d = 1'b0;
    end

    // Clear wipes everything, including any capture computed above.
    if (clear) begin
      state_d   = IDLE;
      count_d   = '0;
      period_d  = '0;
      valid_d   = 1'b0;
      sat_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign saturated    = sat_q;
  assign overrun      = overrun_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter (WIDTH=4 so saturation is reachable).
module tb_pulse_period_meter;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             async_nreset;
  logic             clear;
  logic             enable;
  logic             pulse;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             period_ack;
  logic             saturated;
  logic             overrun;
  logic             state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 0;

  // {saturated, period}
  logic [WIDTH:0] exp_q[$];

  pulse_period_meter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .async_nreset(async_nreset),
    .clear       (clear),
    .enable      (enable),
    .pulse       (pulse),
    .period      (period),
    .period_valid(period_valid),
    .period_ack  (period_ack),
    .saturated   (saturated),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle; outputs are sampled 1ns after the edge.
  task automatic cycle(input logic en, input logic pul, input logic ack);
    enable     = en;
    pulse      = pul;
    period_ack = ack;
    @(posedge clk);
    #1;
    enable     = 1'b0;
    pulse      = 1'b0;
    period_ack = 1'b0;
  endtask

  task automatic do_reset();
    async_nreset = 1'b0;
    clear = 1'b0; enable = 1'b0; pulse = 1'b0; period_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    async_nreset = 1'b1;
    armed = 0;
  endtask

  task automatic check_idle_state(input string tag);
    check_eq({tag, "_period"},  32'(period), 0);
    check_eq({tag, "_valid"},   32'(period_valid), 0);
    check_eq({tag, "_sat"},     32'(saturated), 0);
    check_eq({tag, "_overrun"}, 32'(overrun), 0);
    check_eq({tag, "_state"},   32'(state_dbg), 0);
  endtask

  // Pulse k enabled cycles after the previous one. 'off' disabled cycles
  // (with ignored pulses) are inserted first; they must not count.
  task automatic pulse_after(input string tag, input int k, input int off, input logic ack_on_pulse);
    int e;
    logic [WIDTH:0] exp;
    for (int i = 0; i < off; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 1; i < k; i++) cycle(1'b1, 1'b0, 1'b0);
    if (armed) begin
      e = (k >= MAXV) ? MAXV : k;
      exp_q.push_back({(e == MAXV), WIDTH'(e)});
    end
    cycle(1'b1, 1'b1, ack_on_pulse);
    if (armed) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "_queue_empty"}, 1, 0);
      end else begin
        exp = exp_q.pop_front();
        check_eq({tag, "_period"}, 32'(period), 32'(exp[WIDTH-1:0]));
        check_eq({tag, "_sat"},    32'(saturated), 32'(exp[WIDTH]));
        check_eq({tag, "_valid"},  32'(period_valid), 1);
      end
    end else begin
      check_eq({tag, "_first_no_capture"}, 32'(period_valid), 0);
      check_eq({tag, "_state_measure"},    32'(state_dbg), 1);
    end
    armed = 1;
  endtask

  task automatic ack_idle(input string tag);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq({tag, "_ack_valid"}, 32'(period_valid), 0);
  endtask

  initial begin
    do_reset();
    check_idle_state("reset");

    // 1: 4-cycle trigger pattern
    pulse_after("t1_p0", 1, 0, 1'b0);
    pulse_after("t1_p1", 4, 0, 1'b0);
    ack_idle("t1_a1");
    pulse_after("t1_p2", 4, 0, 1'b0);
    check_eq("t1_overrun", 32'(overrun), 0);
    ack_idle("t1_a2");

    // 2: enable gaps do not count
    pulse_after("t2", 6, 5, 1'b0);
    ack_idle("t2_a");

    // 3: saturation then recovery
    pulse_after("t3_sat", 20, 0, 1'b0);
    ack_idle("t3_a1");
    pulse_after("t3_rec", 3, 0, 1'b0);
    ack_idle("t3_a2");

    // 4: overrun, sticky through ack, cleared by clear
    pulse_after("t4_c1", 5, 0, 1'b0);
    check_eq("t4_no_overrun_yet", 32'(overrun), 0);
    pulse_after("t4_c2", 2, 0, 1'b0);
    check_eq("t4_overrun_set", 32'(overrun), 1);
    ack_idle("t4_a");
    check_eq("t4_overrun_sticky", 32'(overrun), 1);
    clear = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    clear = 1'b0;
    armed = 0;
    check_idle_state("t4_clear");

    // 5: ack coincident with capture
    pulse_after("t5_p0", 1, 0, 1'b0);
    pulse_after("t5_c1", 3, 0, 1'b0);
    pulse_after("t5_c2", 4, 0, 1'b1);
    check_eq("t5_overrun", 32'(overrun), 0);
    ack_idle("t5_a");

    // 6: async reset mid-measurement
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    #2 async_nreset = 1'b0;
    #1;
    check_idle_state("t6_async");
    @(posedge clk);
    #1 async_nreset = 1'b1;
    armed = 0;
    pulse_after("t6_p0", 1, 0, 1'b0);
    pulse_after("t6_p1", 5, 0, 1'b0);
    ack_idle("t6_a");

    // random gaps
    for (int r = 0; r < 8; r++) begin
      pulse_after("rnd", int'($urandom_range(1, 18)), int'($urandom_range(0, 3)), 1'b0);
      ack_idle("rnd_a");
    end
    check_eq("final_overrun", 32'(overrun), 0);
    check_eq("final_queue", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
